burst_mem_ctrl: RTL
===================

BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning 64-bit beats per 32-byte cache line (only 4 supported).
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the beat width in bits.
REQ-003 Port clk, input, 1: the single clock, all state on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 Port mem_read, input, 1: line read request from the cacheline adaptor.
REQ-006 Port mem_write, input, 1: line write request from the cacheline adaptor.
REQ-007 Port mem_address, input, 32: line address; bits [4:0] ignored.
REQ-008 Port mem_wdata, input, 64: write beat presented by the adaptor.
REQ-009 Port mem_resp, output, 1: per-beat response to the adaptor.
REQ-010 Port mem_rdata, output, 64: read beat, valid while mem_resp=1 in a read.
REQ-011 Port sram_req, output, 1: single-beat SRAM access request.
REQ-012 Port sram_we, output, 1: 1=write, 0=read, valid with sram_req.
REQ-013 Port sram_addr, output, 32: 8-byte-aligned beat address.
REQ-014 Port sram_wdata, output, 64: SRAM write data.
REQ-015 Port sram_ack, input, 1: SRAM completes the current access this cycle.
REQ-016 Port sram_rdata, input, 64: SRAM read data, valid on the sram_ack cycle.

Function
REQ-017 The FSM SHALL have states IDLE, RD_FETCH, RD_STREAM, WR_COLLECT, WR_DRAIN, DONE.
REQ-018 In IDLE with mem_read=1, the block SHALL latch base={mem_address[31:5],5'b0}, clear the beat counter and go to RD_FETCH.
REQ-019 In IDLE with mem_write=1 and mem_read=0, the block SHALL latch base, clear the counter and go to WR_COLLECT.
REQ-020 If mem_read and mem_write are both 1 in IDLE, read SHALL win.
REQ-021 The beat address SHALL be base + 8*beat, 32-bit wrap-around.
REQ-022 RD_FETCH: hold sram_req=1, sram_we=0 until sram_ack; on ack store sram_rdata into buffer[beat] and increment beat; after beat 3 is acked, clear beat and go to RD_STREAM.
REQ-023 RD_STREAM: mem_resp=1 and mem_rdata=buffer[beat] for exactly 4 consecutive cycles, beats 0..3, then go to DONE.
REQ-024 WR_COLLECT: mem_resp=1 for exactly 4 consecutive cycles, capturing mem_wdata into buffer[beat] each cycle, then go to WR_DRAIN.
REQ-025 WR_DRAIN: hold sram_req=1, sram_we=1, sram_wdata=buffer[beat] until sram_ack, once per beat; after beat 3 is acked go to DONE.
REQ-026 DONE SHALL last one cycle with mem_resp=0, then go to IDLE; requests SHALL be sampled only in IDLE.
REQ-027 mem_resp SHALL be 0 in IDLE, RD_FETCH, WR_DRAIN and DONE.
REQ-028 sram_req SHALL be 0 outside RD_FETCH and WR_DRAIN; at most one access SHALL be outstanding.
REQ-029 sram_addr, sram_we and sram_wdata SHALL be stable while sram_req=1 and sram_ack=0.
REQ-030 With zero-wait SRAM (ack on the request cycle) and a request at cycle T, beat 0 of a read SHALL appear at T+5 and the last beat at T+8.
REQ-031 With zero-wait SRAM, a write SHALL take resp cycles T+1..T+4, drain cycles T+5..T+8 and return to IDLE at T+10.
REQ-032 A request deasserted before IDLE samples it SHALL be ignored; a deassert mid-burst SHALL NOT abort the burst.

Reset
REQ-033 On reset_n=0 at a clock edge: state=IDLE, beat=0, base=0, mem_resp=0, mem_rdata=0, sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further SRAM access; buffer contents are don't-care.

Structure
REQ-035 Package burst_mem_pkg SHALL hold the state enum, BURST_LEN, DATA_W and the line-offset width (5).
REQ-036 The 4x64 storage SHALL be the sub-module burst_line_buffer (one write port, one read port, 2-bit index).

Verification
REQ-037 Zero-wait read of line 0x0000_1040 holding beats A0..A3 -> sram_addr 0x1040,0x1048,0x1050,0x1058; mem_resp high T+5..T+8 with A0..A3 in order.
REQ-038 Write of line 0x0000_2000 with beats W0..W3 -> 4 resp cycles, then 4 SRAM writes to 0x2000..0x2018 with W0..W3; a read-back of the line returns W0..W3.
REQ-039 SRAM ack delayed 3 cycles per beat -> request held stable during each wait, stream still 4 back-to-back beats.
REQ-040 mem_read=mem_write=1 at address 0x3000 -> a read is performed and no SRAM write occurs.
REQ-041 reset_n=0 during RD_FETCH beat 2 -> next cycle state IDLE and all outputs 0; a following read of 0x1040 completes correctly.
REQ-042 Base 0xFFFF_FFE0 -> beat addresses 0xFFFF_FFE0..0xFFFF_FFF8 with no carry corruption.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_mem_pkg;

    localparam int BURST_LEN  = 4;   // 64-bit beats per 32-byte line
    localparam int DATA_W     = 64;  // beat width in bits
    localparam int LINE_OFF_W = 5;   // byte offset bits inside a line
    localparam int BEAT_W     = 2;   // beat index width

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_STREAM,
        WR_COLLECT,
        WR_DRAIN,
        DONE
    } state_t;

    // Byte address of one beat inside a line; plain 32-bit add so the
    // result wraps at the top of the address space.
    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [BEAT_W-1:0] beat);
        return base + {{(32 - BEAT_W - 3){1'b0}}, beat, 3'b000};
    endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// One cache line of beat storage: one write port, one read port.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none, both ports are always ready.
// Ports: clk; wr_en/wr_idx/wr_data write port; rd_idx/rd_data read port.
module burst_line_buffer
    import burst_mem_pkg::*;
#(
    parameter int DATA_W_P = 64
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [BEAT_W-1:0]   wr_idx,
    input  logic [DATA_W_P-1:0] wr_data,
    input  logic [BEAT_W-1:0]   rd_idx,
    output logic [DATA_W_P-1:0] rd_data
);

    logic [DATA_W_P-1:0] mem [2**BEAT_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/burst_mem_ctrl.sv
// Bridges 32-byte line requests onto a single-beat SRAM port.
// Latency: zero-wait read streams beats at T+5..T+8, write resps T+1..T+4.
// Backpressure: SRAM stalls via sram_ack; requests sampled only in IDLE.
// Ports: clk, reset_n; mem_* line side (read/write/address/wdata in,
//        resp/rdata out); sram_* beat side (req/we/addr/wdata out, ack/rdata in).
module burst_mem_ctrl
    import burst_mem_pkg::*;
#(
    parameter int BURST_LEN_P = 4,
    parameter int DATA_W_P    = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_address,
    input  logic [DATA_W_P-1:0] mem_wdata,
    output logic                mem_resp,
    output logic [DATA_W_P-1:0] mem_rdata,
    output logic                sram_req,
    output logic                sram_we,
    output logic [31:0]         sram_addr,
    output logic [DATA_W_P-1:0] sram_wdata,
    input  logic                sram_ack,
    input  logic [DATA_W_P-1:0] sram_rdata
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN_P - 1);

    state_t              state;
    logic [31:0]         base;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_inc;
    logic [BEAT_W-1:0]   rd_idx;
    logic                buf_we;
    logic [DATA_W_P-1:0] buf_wdata;
    logic [DATA_W_P-1:0] buf_rdata;
    logic [31:0]         line_addr;
    logic                unused_offset;

    assign line_addr     = {mem_address[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    assign unused_offset = ^mem_address[LINE_OFF_W-1:0];
    assign beat_inc      = beat + BEAT_W'(1);

    // Fetched read beats and collected write beats share the one buffer.
    assign buf_we    = (state == WR_COLLECT) || ((state == RD_FETCH) && sram_ack);
    assign buf_wdata = (state == WR_COLLECT) ? mem_wdata : sram_rdata;

    // mem_rdata and sram_wdata are registered, so the buffer is read one
    // beat ahead: entry 0 on the entry edge, then beat+1 on each advance.
    assign rd_idx = ((state == RD_STREAM) || (state == WR_DRAIN)) ? beat_inc : '0;

    burst_line_buffer #(.DATA_W_P(DATA_W_P)) u_line_buffer (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (beat),
        .wr_data (buf_wdata),
        .rd_idx  (rd_idx),
        .rd_data (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            base       <= '0;
            beat       <= '0;
            mem_resp   <= 1'b0;
            mem_rdata  <= '0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Read wins when both requests are raised together.
                    if (mem_read) begin
                        base      <= line_addr;
                        beat      <= '0;
                        state     <= RD_FETCH;
                        sram_req  <= 1'b1;
                        sram_we   <= 1'b0;
                        sram_addr <= line_addr;
                    end else if (mem_write) begin
                        base     <= line_addr;
                        beat     <= '0;
                        state    <= WR_COLLECT;
                        mem_resp <= 1'b1;
                    end
                end
                RD_FETCH: begin
                    if (sram_ack) begin
                        if (beat == LAST_BEAT) begin
                            beat      <= '0;
                            state     <= RD_STREAM;
                            sram_req  <= 1'b0;
                            mem_resp  <= 1'b1;
                            mem_rdata <= buf_rdata;
                        end else begin
                            beat      <= beat_inc;
                            sram_addr <= beat_addr(base, beat_inc);
                        end
                    end
                end
                RD_STREAM: begin
                    if (beat == LAST_BEAT) begin
                        beat      <= '0;
                        state     <= DONE;
                        mem_resp  <= 1'b0;
                        mem_rdata <= '0;
                    end else begin
                        beat      <= beat_inc;
                        mem_rdata <= buf_rdata;
                    end
                end
                WR_COLLECT: begin
                    if (beat == LAST_BEAT) begin
                        beat       <= '0;
                        state      <= WR_DRAIN;
                        mem_resp   <= 1'b0;
                        sram_req   <= 1'b1;
                        sram_we    <= 1'b1;
                        sram_addr  <= base;
                        sram_wdata <= buf_rdata;
                    end else begin
                        beat <= beat_inc;
                    end
                end
                WR_DRAIN: begin
                    if (sram_ack) begin
                        if (beat == LAST_BEAT) begin
                            beat     <= '0;
                            state    <= DONE;
                            sram_req <= 1'b0;
                            sram_we  <= 1'b0;
                        end else begin
                            beat       <= beat_inc;
                            sram_addr  <= beat_addr(base, beat_inc);
                            sram_wdata <= buf_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
